soc_bus_arb: RTL and testbench
==============================

Name: soc_bus_arb

Overview:
- Round-robin arbiter sharing one SOC-bus target port among NUM_REQ requesters (e.g. CPU data port, DMA, debug bridge).
- Sits between bus masters and the shared peripheral/memory decoder.
- One outstanding transaction at a time. A bus-timeout watchdog, paced by the timebase 1 µs tick, aborts hung target accesses and reports an error to the owning requester.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_US, 16: abort threshold in µs; 0 disables the timeout.
- ERRW, 16: width of the saturating error counter.

Ports:
- clk  in  1  SOC clock (80 MHz).
- arst_n  in  1  asynchronous active-low reset.
- tick_1us  in  1  one-clk pulse every 1 µs, from the timebase generator.
- req_vld  in  NUM_REQ  request pending; held high until the matching req_done.
- req_addr  in  NUM_REQ x soc_addr_t  word address.
- req_we  in  NUM_REQ x soc_we_t  byte write enables; all-zero means read.
- req_wdat  in  NUM_REQ x soc_data_t  write data.
- req_done  out  NUM_REQ  one-clk completion pulse, one-hot.
- req_err  out  1  valid with req_done; 1 = timeout abort.
- req_rdat  out  soc_data_t  read data; valid with req_done.
- tgt_vld  out  1  target access valid; held until tgt_rdy or abort.
- tgt_addr  out  soc_addr_t  latched address.
- tgt_we  out  soc_we_t  latched write enables.
- tgt_wdat  out  soc_data_t  latched write data.
- tgt_rdy  in  1  target completes the access this clk; tgt_rdat valid.
- tgt_rdat  in  soc_data_t  read data.
- gnt_idx  out  $clog2(NUM_REQ)  index of current or last granted requester.
- err_cnt  out  ERRW  count of timeouts, saturating at all-ones.

Behaviour:
- All outputs registered. Reset values: everything 0, except last-grant pointer = NUM_REQ-1, so requester 0 has top priority after reset.
- State machine (arb_state_t), transitions:
  - IDLE: if any req_vld, pick the first set bit searching upward from (last_gnt+1) mod NUM_REQ with wrap. Latch addr/we/wdat and the index, set tgt_vld, go to BUSY. If no request, stay.
  - BUSY: tgt_vld=1 and tgt_* stable. On tgt_rdy: capture tgt_rdat, drop tgt_vld, pulse req_done[gnt] with err=0, go to DONE.
  - BUSY timeout: tmo_cnt increments on each tick_1us. When the increment would reach TIMEOUT_US: drop tgt_vld, req_rdat=0, pulse req_done[gnt] with err=1, increment err_cnt, go to DONE.
  - DONE: outputs req_done for one clk, then IDLE. No arbitration in this clk, which gives the requester one clk to deassert or replace req_vld.
- Latency: req_vld high in IDLE at clk T gives tgt_vld at T+1. tgt_rdy at T+k gives req_done at T+k+1, and IDLE at T+k+2. Minimum 3 clks per transaction.
- tmo_cnt width is $clog2(TIMEOUT_US+1). It clears on entering BUSY.
- The first tick may arrive at any phase, so the abort occurs between (TIMEOUT_US-1) µs and TIMEOUT_US µs after tgt_vld rises.
- tgt_rdy and the timeout in the same clk: tgt_rdy wins, normal completion, err=0.
- tgt_rdy while not BUSY: ignored.
- A requester deasserting req_vld during BUSY is ignored; the latched transaction completes.
- req_rdat holds its last value between transactions. req_err is meaningful only with req_done.
- last_gnt updates on entry to BUSY.
- Async reset mid-transaction: tgt_vld and req_done drop immediately, the FSM returns to IDLE, the pointer resets, and err_cnt clears.

Decomposition:
- Add to soc_pkg:
  - arb_state_t enum {IDLE, BUSY, DONE}.
  - SOC_ARB_NREQ_MAX = 8.
  - cnt_1us_t reused for the tick source.
- Sub-module soc_rr_pick: combinational round-robin picker (req vector, last index -> grant index and any-valid), parameterized by NUM_REQ.

Test Plan (NUM_REQ=4, TIMEOUT_US=16):
- Write: req1 only, addr word 0x40, we=4'hF, wdat 0xCAFE_0001, req_vld at T, tgt_rdy at T+2 -> tgt_vld at T+1..T+2 with matching fields; req_done[1] at T+3 only; err=0; gnt_idx=1.
- Read: req2, we=0, tgt_rdat 0x1234_5678 with tgt_rdy -> req_rdat=0x1234_5678 on the req_done[2] clk.
- Fairness: all four requesters continuously valid with tgt_rdy=1 -> grant order 0,1,2,3,0,1, each transaction 3 clks.
- Timeout: tgt_rdy never asserted, tick_1us every 80 clks -> req_done with err=1 after the 16th tick; req_rdat=0; tgt_vld low; err_cnt=1. With err_cnt preloaded by 65535 aborts -> stays 0xFFFF.
- Coincidence: tgt_rdy in the same clk as the 16th tick -> err=0, err_cnt unchanged.
- Reset: arst_n low mid-BUSY -> tgt_vld=0 within the same clk. After release, only req2 pending -> granted. Then req0 and req3 pending -> req3 granted before req0.

Source files
------------

// File: rtl/soc_bus_arb_pkg.sv
// Shared types and constants for the SOC-bus round-robin arbiter.
package soc_bus_arb_pkg;

  // Word address, byte enables and data of one SOC-bus access.
  typedef logic [29:0] soc_addr_t;
  typedef logic [3:0]  soc_we_t;
  typedef logic [31:0] soc_data_t;

  // Clock-cycle counter inside one microsecond of the 80 MHz timebase.
  typedef logic [6:0]  cnt_1us_t;

  localparam int SOC_ARB_NREQ_MAX = 8;
  localparam int SOC_CLK_PER_US   = 80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/soc_bus_arb_if.sv
// Requester-side and target-side handshake of the SOC-bus arbiter.
// The master modport is the arbiter itself; the slave modport is its environment.
interface soc_bus_arb_if #(
  parameter int NUM_REQ = 4
);
  import soc_bus_arb_pkg::*;

  logic [NUM_REQ-1:0]      req_vld;
  soc_addr_t [NUM_REQ-1:0] req_addr;
  soc_we_t [NUM_REQ-1:0]   req_we;
  soc_data_t [NUM_REQ-1:0] req_wdat;
  logic [NUM_REQ-1:0]      req_done;
  logic                    req_err;
  soc_data_t               req_rdat;

  logic                    tgt_vld;
  soc_addr_t               tgt_addr;
  soc_we_t                 tgt_we;
  soc_data_t               tgt_wdat;
  logic                    tgt_rdy;
  soc_data_t               tgt_rdat;

  modport master (
    input  req_vld, req_addr, req_we, req_wdat, tgt_rdy, tgt_rdat,
    output req_done, req_err, req_rdat, tgt_vld, tgt_addr, tgt_we, tgt_wdat
  );

  modport slave (
    output req_vld, req_addr, req_we, req_wdat, tgt_rdy, tgt_rdat,
    input  req_done, req_err, req_rdat, tgt_vld, tgt_addr, tgt_we, tgt_wdat
  );

endinterface

// File: rtl/soc_bus_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after last_idx+1, with wrap.
module soc_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_idx,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       any_vld
);

  localparam int IW = $clog2(NUM_REQ);

  // Scan from the farthest offset down to the nearest so the nearest hit wins.
  always_comb begin
    int   cand_s;
    logic hit_s;
    gnt_idx = '0;
    any_vld = 1'b0;
    cand_s  = 0;
    hit_s   = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand_s  = int'(last_idx) + i;
      cand_s  = (cand_s >= NUM_REQ) ? (cand_s - NUM_REQ) : cand_s;
      hit_s   = req[IW'(cand_s)];
      gnt_idx = hit_s ? IW'(cand_s) : gnt_idx;
      any_vld = any_vld | hit_s;
    end
  end

endmodule

// File: rtl/soc_bus_arb.sv
// Round-robin arbiter sharing one SOC-bus target among NUM_REQ requesters,
// one access at a time, with a microsecond-paced watchdog on hung targets.
module soc_bus_arb
  import soc_bus_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT_US = 16,
  parameter int ERRW       = 16
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       tick_1us,
  soc_bus_arb_if.master              bus,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic [ERRW-1:0]            err_cnt
);

  localparam int IW = $clog2(NUM_REQ);
  // A disabled watchdog still keeps a 1-bit counter so no vector is zero-width.
  localparam int TW = (TIMEOUT_US > 0) ? $clog2(TIMEOUT_US + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_US > 0) ? (TIMEOUT_US - 1) : 0);
  localparam logic TMO_EN = (TIMEOUT_US > 0);

  arb_state_t      state_r;
  logic [IW-1:0]   last_gnt_r;
  logic [TW-1:0]   tmo_cnt_r;
  logic [IW-1:0]   pick_idx_s;
  logic            pick_vld_s;
  logic            tmo_hit_s;

  soc_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (bus.req_vld),
    .last_idx (last_gnt_r),
    .gnt_idx  (pick_idx_s),
    .any_vld  (pick_vld_s)
  );

  // The tick that would bring the counter up to TIMEOUT_US ends the access.
  assign tmo_hit_s = TMO_EN && tick_1us && (tmo_cnt_r == TMO_LAST);

  // Arbitration FSM; every bus-facing output is a register written here.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r      <= IDLE;
      last_gnt_r   <= IW'(NUM_REQ - 1);
      tmo_cnt_r    <= '0;
      gnt_idx      <= '0;
      err_cnt      <= '0;
      bus.req_done <= '0;
      bus.req_err  <= 1'b0;
      bus.req_rdat <= '0;
      bus.tgt_vld  <= 1'b0;
      bus.tgt_addr <= '0;
      bus.tgt_we   <= '0;
      bus.tgt_wdat <= '0;
    end else begin
      bus.req_done <= '0;
      case (state_r)
        IDLE: begin
          if (pick_vld_s) begin
            bus.tgt_vld  <= 1'b1;
            bus.tgt_addr <= bus.req_addr[pick_idx_s];
            bus.tgt_we   <= bus.req_we[pick_idx_s];
            bus.tgt_wdat <= bus.req_wdat[pick_idx_s];
            gnt_idx      <= pick_idx_s;
            last_gnt_r   <= pick_idx_s;
            tmo_cnt_r    <= '0;
            state_r      <= BUSY;
          end
        end
        BUSY: begin
          // A ready target beats a watchdog expiry in the same clock.
          if (bus.tgt_rdy) begin
            bus.tgt_vld           <= 1'b0;
            bus.req_rdat          <= bus.tgt_rdat;
            bus.req_err           <= 1'b0;
            bus.req_done[gnt_idx] <= 1'b1;
            state_r               <= DONE;
          end else if (tmo_hit_s) begin
            bus.tgt_vld           <= 1'b0;
            bus.req_rdat          <= '0;
            bus.req_err           <= 1'b1;
            bus.req_done[gnt_idx] <= 1'b1;
            if (err_cnt != {ERRW{1'b1}}) begin
              err_cnt <= err_cnt + ERRW'(1);
            end
            state_r               <= DONE;
          end else if (tick_1us) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        // One quiet clock lets the finished requester drop or replace its request.
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_bus_arb.sv
// Self-checking bench for soc_bus_arb: directed scenarios plus randomized
// traffic compared against a transaction-level round-robin model.
module tb_soc_bus_arb;
  import soc_bus_arb_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        tick_1us;
  logic        tick2;
  logic [1:0]  gnt_idx;
  logic [15:0] err_cnt;
  logic [0:0]  gnt_idx2;
  logic [1:0]  err_cnt2;

  soc_bus_arb_if #(.NUM_REQ(4)) bus ();
  soc_bus_arb_if #(.NUM_REQ(2)) bus2 ();

  soc_bus_arb #(.NUM_REQ(4), .TIMEOUT_US(16), .ERRW(16)) dut (
    .clk(clk), .arst_n(arst_n), .tick_1us(tick_1us), .bus(bus),
    .gnt_idx(gnt_idx), .err_cnt(err_cnt)
  );

  // Small instance: every tick aborts, 2-bit counter shows saturation quickly.
  soc_bus_arb #(.NUM_REQ(2), .TIMEOUT_US(1), .ERRW(2)) dut2 (
    .clk(clk), .arst_n(arst_n), .tick_1us(tick2), .bus(bus2),
    .gnt_idx(gnt_idx2), .err_cnt(err_cnt2)
  );

  always #6 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  cnt_1us_t  us_cnt = '0;

  int        m_last;
  logic [3:0] pend;
  soc_addr_t m_addr [4];
  soc_we_t   m_we   [4];
  soc_data_t m_wdat [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; also paces tick_1us.
  task automatic step();
    @(posedge clk);
    #1;
    us_cnt   = (us_cnt == cnt_1us_t'(SOC_CLK_PER_US - 1)) ? '0 : us_cnt + cnt_1us_t'(1);
    tick_1us = (us_cnt == cnt_1us_t'(SOC_CLK_PER_US - 1));
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i] = m_addr[i];
      bus.req_we[i]   = m_we[i];
      bus.req_wdat[i] = m_wdat[i];
    end
    bus.req_vld = pend;
  endtask

  task automatic new_req(input int i);
    m_addr[i] = soc_addr_t'($urandom);
    m_we[i]   = soc_we_t'($urandom_range(0, 15));
    m_wdat[i] = $urandom;
  endtask

  // Reference rule: first pending requester scanning upward from last+1, wrapping.
  function automatic int rr_model(input logic [3:0] p, input int last);
    logic [3:0] sh;
    for (int k = 1; k <= 4; k++) begin
      sh = p >> ((last + k) % 4);
      if (sh[0]) return (last + k) % 4;
    end
    return -1;
  endfunction

  initial begin
    int        nt;
    bit        hit;
    bit        mark;
    int        exp_g;
    int        d;
    soc_data_t rd;

    arst_n = 1'b0;
    tick_1us = 1'b0;
    tick2 = 1'b1;
    pend = '0;
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = '0; m_we[i] = '0; m_wdat[i] = '0;
    end
    drive();
    bus.tgt_rdy = 1'b0; bus.tgt_rdat = '0;
    bus2.req_vld = '0; bus2.req_addr = '0; bus2.req_we = '0; bus2.req_wdat = '0;
    bus2.tgt_rdy = 1'b0; bus2.tgt_rdat = '0;
    repeat (3) step();
    arst_n = 1'b1;
    m_last = 3;

    chk("rst_tgt_vld", bus.tgt_vld, 0);
    chk("rst_req_done", bus.req_done, 0);
    chk("rst_gnt_idx", gnt_idx, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_req_rdat", bus.req_rdat, 0);
    step();

    // Write from requester 1, target ready two clocks after the request.
    m_addr[1] = 30'h40; m_we[1] = 4'hF; m_wdat[1] = 32'hCAFE_0001;
    pend = 4'b0010; drive();
    step();
    chk("wr_vld_t1", bus.tgt_vld, 1);
    chk("wr_addr", bus.tgt_addr, 30'h40);
    chk("wr_we", bus.tgt_we, 4'hF);
    chk("wr_wdat", bus.tgt_wdat, 32'hCAFE_0001);
    chk("wr_gnt", gnt_idx, 1);
    chk("wr_done_t1", bus.req_done, 0);
    step();
    chk("wr_vld_t2", bus.tgt_vld, 1);
    chk("wr_done_t2", bus.req_done, 0);
    bus.tgt_rdy = 1'b1; bus.tgt_rdat = 32'hDEAD_BEEF;
    step();
    chk("wr_done_t3", bus.req_done, 4'b0010);
    chk("wr_err", bus.req_err, 0);
    chk("wr_vld_t3", bus.tgt_vld, 0);
    bus.tgt_rdy = 1'b0; pend = '0; drive();
    step();
    chk("wr_done_t4", bus.req_done, 0);
    m_last = 1;

    // Read from requester 2.
    new_req(2); m_we[2] = 4'h0; pend = 4'b0100; drive();
    step();
    chk("rd_gnt", gnt_idx, 2);
    chk("rd_we", bus.tgt_we, 0);
    bus.tgt_rdy = 1'b1; bus.tgt_rdat = 32'h1234_5678;
    step();
    chk("rd_done", bus.req_done, 4'b0100);
    chk("rd_rdat", bus.req_rdat, 32'h1234_5678);
    chk("rd_err", bus.req_err, 0);
    bus.tgt_rdy = 1'b0; pend = '0; drive();
    step();
    m_last = 2;

    // Timeout: requester 3, target never ready; abort after the 16th tick in BUSY.
    new_req(3); pend = 4'b1000; drive();
    nt = 0; hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      if (tick_1us && bus.tgt_vld) nt++;
      mark = (nt == 16);
      step();
      if (mark) begin
        hit = 1'b1;
        chk("tmo_done", bus.req_done, 4'b1000);
        chk("tmo_err", bus.req_err, 1);
        chk("tmo_rdat", bus.req_rdat, 0);
        chk("tmo_vld", bus.tgt_vld, 0);
        chk("tmo_err_cnt", err_cnt, 1);
        pend = '0; drive();
      end else begin
        chk("tmo_early_done", bus.req_done, 0);
      end
    end
    if (!hit) chk("tmo_bound", 0, 1);
    step();
    m_last = 3;

    // Coincidence: tgt_rdy in the clock of the 16th tick completes normally.
    new_req(3); pend = 4'b1000; drive();
    nt = 0; hit = 1'b0; rd = $urandom;
    for (int c = 0; c < 2000 && !hit; c++) begin
      if (tick_1us && bus.tgt_vld) nt++;
      mark = (nt == 16);
      bus.tgt_rdy = mark; bus.tgt_rdat = rd;
      step();
      if (mark) begin
        hit = 1'b1;
        bus.tgt_rdy = 1'b0;
        chk("coin_done", bus.req_done, 4'b1000);
        chk("coin_err", bus.req_err, 0);
        chk("coin_rdat", bus.req_rdat, rd);
        chk("coin_err_cnt", err_cnt, 1);
        pend = '0; drive();
      end
    end
    if (!hit) chk("coin_bound", 0, 1);
    step();
    m_last = 3;

    // Fairness: all requesters held valid with an always-ready target.
    for (int i = 0; i < 4; i++) new_req(i);
    pend = 4'b1111; drive(); bus.tgt_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      exp_g = (m_last + 1) % 4;
      m_last = exp_g;
      chk("fair_vld", bus.tgt_vld, 1);
      chk("fair_gnt", gnt_idx, exp_g);
      chk("fair_addr", bus.tgt_addr, m_addr[exp_g]);
      step();
      chk("fair_done", bus.req_done, 4'b0001 << exp_g);
      if (k == 5) begin
        pend = '0; drive(); bus.tgt_rdy = 1'b0;
      end
      step();
      chk("fair_gap", bus.tgt_vld, 0);
    end

    // Random traffic against the round-robin model.
    for (int t = 0; t < 30; t++) begin
      bus.tgt_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          new_req(i); pend[i] = 1'b1;
        end
      end
      if (pend == 4'b0000) begin
        d = $urandom_range(0, 3); new_req(d); pend[d] = 1'b1;
      end
      drive();
      exp_g = rr_model(pend, m_last);
      m_last = exp_g;
      step();
      chk("rnd_vld", bus.tgt_vld, 1);
      chk("rnd_gnt", gnt_idx, exp_g);
      chk("rnd_addr", bus.tgt_addr, m_addr[exp_g]);
      chk("rnd_we", bus.tgt_we, m_we[exp_g]);
      chk("rnd_wdat", bus.tgt_wdat, m_wdat[exp_g]);
      d = $urandom_range(0, 4);
      for (int w = 0; w < d; w++) begin
        bus.req_vld[exp_g] = 1'($urandom_range(0, 1));
        step();
        chk("rnd_hold_vld", bus.tgt_vld, 1);
        chk("rnd_hold_addr", bus.tgt_addr, m_addr[exp_g]);
        chk("rnd_hold_done", bus.req_done, 0);
      end
      rd = $urandom;
      bus.tgt_rdy = 1'b1; bus.tgt_rdat = rd;
      step();
      chk("rnd_done", bus.req_done, 4'b0001 << exp_g);
      chk("rnd_rdat", bus.req_rdat, rd);
      chk("rnd_err", bus.req_err, 0);
      pend[exp_g] = 1'b0; drive();
      bus.tgt_rdy = 1'($urandom_range(0, 1));
      step();
      chk("rnd_idle_done", bus.req_done, 0);
      chk("rnd_idle_vld", bus.tgt_vld, 0);
    end
    bus.tgt_rdy = 1'b0; pend = '0; drive();
    step();

    // Asynchronous reset in the middle of an access.
    new_req(0); pend = 4'b0001; drive();
    step();
    chk("ar_busy", bus.tgt_vld, 1);
    #3;
    arst_n = 1'b0;
    #1;
    chk("ar_vld", bus.tgt_vld, 0);
    chk("ar_done", bus.req_done, 0);
    chk("ar_err_cnt", err_cnt, 0);
    pend = '0; drive();
    step();
    step();
    arst_n = 1'b1;
    new_req(2); pend = 4'b0100; drive();
    step();
    chk("ar_gnt2", gnt_idx, 2);
    chk("ar_vld2", bus.tgt_vld, 1);
    bus.tgt_rdy = 1'b1;
    step();
    chk("ar_done2", bus.req_done, 4'b0100);
    bus.tgt_rdy = 1'b0; pend = '0; drive();
    step();
    new_req(0); new_req(3); pend = 4'b1001; drive();
    step();
    chk("ar_gnt3", gnt_idx, 3);
    bus.tgt_rdy = 1'b1;
    step();
    chk("ar_done3", bus.req_done, 4'b1000);
    bus.tgt_rdy = 1'b0; pend = '0; drive();
    step();

    // Error counter saturation on the small instance.
    bus2.req_vld = 2'b01;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("sat_vld", bus2.tgt_vld, 1);
      step();
      chk("sat_done", bus2.req_done, 2'b01);
      chk("sat_err", bus2.req_err, 1);
      chk("sat_cnt", err_cnt2, (k + 1 > 3) ? 3 : k + 1);
      step();
    end
    bus2.req_vld = 2'b00;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
